// File: rtl/key_pkg.sv
// rtl/key_pkg.sv - shared types and constants for the key debounce bank
package key_pkg;

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    PRESS_WAIT   = 2'd1,
    HELD         = 2'd2,
    RELEASE_WAIT = 2'd3
  } key_state_e;

  // Key channel indices as wired on the front panel
  localparam int KEY_E = 0;
  localparam int KEY_U = 1;
  localparam int KEY_D = 2;
  localparam int KEY_L = 3;
  localparam int KEY_R = 4;

  // Default timing for a 50 MHz clkin
  localparam int N_KEYS_DEF          = 5;
  localparam int DEBOUNCE_CYCLES_DEF = 1000000;   // 20 ms
  localparam int REPEAT_DELAY_DEF    = 25000000;  // 500 ms
  localparam int REPEAT_PERIOD_DEF   = 10000000;  // 200 ms

  // Bits needed for a counter that must hold max_val
  function automatic int cnt_w(input int max_val);
    if (max_val < 2) return 1;
    return $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/key_debounce_channel.sv
// rtl/key_debounce_channel.sv - synchroniser, debounce FSM and auto-repeat for one key
module key_debounce_channel
  import key_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int REPEAT_DELAY    = REPEAT_DELAY_DEF,
  parameter int REPEAT_PERIOD   = REPEAT_PERIOD_DEF
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_key_raw,
  input  logic i_repeat_en,
  output logic o_level,
  output logic o_press,
  output logic o_release,
  output logic o_repeat
);

  localparam int DEB_W = cnt_w(DEBOUNCE_CYCLES - 1);
  localparam int REP_W = cnt_w(REPEAT_DELAY);
  localparam int PER_W = cnt_w(REPEAT_PERIOD - 1);

  localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [REP_W-1:0] REP_LAST = REP_W'(REPEAT_DELAY);
  localparam logic [PER_W-1:0] PER_LAST = PER_W'(REPEAT_PERIOD - 1);

  logic             r_sync1;
  logic             r_sync2;
  key_state_e       r_state;
  logic [DEB_W-1:0] r_deb_cnt;
  logic [REP_W-1:0] r_rep_cnt;
  logic [PER_W-1:0] r_per_cnt;

  logic             w_p;
  key_state_e       w_state_nxt;
  logic [DEB_W-1:0] w_deb_nxt;
  logic [REP_W-1:0] w_rep_nxt;
  logic [REP_W-1:0] w_rep_inc;
  logic [PER_W-1:0] w_per_nxt;
  logic             w_press;
  logic             w_release;
  logic             w_tick;

  // Pads idle high, so both flops reset to the released level
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
    end else begin
      r_sync1 <= i_key_raw;
      r_sync2 <= r_sync1;
    end
  end

  assign w_p       = ~r_sync2;
  assign w_rep_inc = r_rep_cnt + REP_W'(1);

  // State and counter registers
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state   <= IDLE;
      r_deb_cnt <= '0;
      r_rep_cnt <= '0;
      r_per_cnt <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_deb_cnt <= w_deb_nxt;
      r_rep_cnt <= w_rep_nxt;
      r_per_cnt <= w_per_nxt;
    end
  end

  // Next-state, counters and pulse decode; repeat ticks come from rep_cnt
  // reaching the delay, then from a period counter once rep_cnt has saturated
  always_comb begin
    w_state_nxt = r_state;
    w_deb_nxt   = r_deb_cnt;
    w_rep_nxt   = r_rep_cnt;
    w_per_nxt   = r_per_cnt;
    w_press     = 1'b0;
    w_release   = 1'b0;
    w_tick      = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_p) begin
          w_state_nxt = PRESS_WAIT;
          w_deb_nxt   = DEB_W'(1);
        end else begin
          w_deb_nxt   = '0;
        end
      end
      PRESS_WAIT: begin
        if (w_p) begin
          if (r_deb_cnt == DEB_LAST) begin
            w_state_nxt = HELD;
            w_press     = 1'b1;
            w_deb_nxt   = '0;
            w_rep_nxt   = '0;
            w_per_nxt   = '0;
          end else begin
            w_deb_nxt   = r_deb_cnt + DEB_W'(1);
          end
        end else begin
          w_state_nxt = IDLE;
          w_deb_nxt   = '0;
        end
      end
      HELD: begin
        if (w_p) begin
          w_deb_nxt = '0;
          if (r_rep_cnt != REP_LAST) begin
            w_rep_nxt = w_rep_inc;
            w_tick    = (w_rep_inc == REP_LAST);
          end else if (r_per_cnt == PER_LAST) begin
            w_per_nxt = '0;
            w_tick    = 1'b1;
          end else begin
            w_per_nxt = r_per_cnt + PER_W'(1);
          end
        end else begin
          w_state_nxt = RELEASE_WAIT;
          w_deb_nxt   = DEB_W'(1);
        end
      end
      RELEASE_WAIT: begin
        if (!w_p) begin
          if (r_deb_cnt == DEB_LAST) begin
            w_state_nxt = IDLE;
            w_release   = 1'b1;
            w_deb_nxt   = '0;
          end else begin
            w_deb_nxt   = r_deb_cnt + DEB_W'(1);
          end
        end else begin
          w_state_nxt = HELD;
          w_deb_nxt   = '0;
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_deb_nxt   = '0;
      end
    endcase
  end

  // Level follows the pulses in the same cycle; everything is forced low in reset
  assign o_press   = ~i_rst & w_press;
  assign o_release = ~i_rst & w_release;
  assign o_repeat  = ~i_rst & w_tick & i_repeat_en;
  assign o_level   = ~i_rst & ((r_state == HELD) |
                               ((r_state == RELEASE_WAIT) & ~w_release) |
                               w_press);

endmodule

// File: rtl/key_debounce_bank.sv
// rtl/key_debounce_bank.sv - bank of independent debounced key channels
module key_debounce_bank
  import key_pkg::*;
#(
  parameter int N_KEYS          = N_KEYS_DEF,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int REPEAT_DELAY    = REPEAT_DELAY_DEF,
  parameter int REPEAT_PERIOD   = REPEAT_PERIOD_DEF
) (
  input  logic              clkin,
  input  logic              rst,
  input  logic [N_KEYS-1:0] key_raw,
  input  logic [N_KEYS-1:0] repeat_en,
  output logic [N_KEYS-1:0] key_level,
  output logic [N_KEYS-1:0] key_press,
  output logic [N_KEYS-1:0] key_release,
  output logic [N_KEYS-1:0] key_repeat
);

  for (genvar g = 0; g < N_KEYS; g++) begin : g_ch
    key_debounce_channel #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .REPEAT_DELAY   (REPEAT_DELAY),
      .REPEAT_PERIOD  (REPEAT_PERIOD)
    ) u_ch (
      .i_clk      (clkin),
      .i_rst      (rst),
      .i_key_raw  (key_raw[g]),
      .i_repeat_en(repeat_en[g]),
      .o_level    (key_level[g]),
      .o_press    (key_press[g]),
      .o_release  (key_release[g]),
      .o_repeat   (key_repeat[g])
    );
  end

endmodule

// File: tb/tb_key_debounce_bank.sv
// tb/tb_key_debounce_bank.sv - scoreboard bench for key_debounce_bank
module tb_key_debounce_bank;
  import key_pkg::*;

  localparam int NK = 5;

  localparam int EV_PRESS = 0;
  localparam int EV_REL   = 1;
  localparam int EV_REP   = 2;
  localparam int EV_RST   = 3;

  typedef struct {
    int cyc;
    int kind;
    int key;
  } ev_t;

  logic          clk = 1'b0;
  logic          rst;
  logic [NK-1:0] key_raw;
  logic [NK-1:0] repeat_en;
  logic [NK-1:0] key_level;
  logic [NK-1:0] key_press;
  logic [NK-1:0] key_release;
  logic [NK-1:0] key_repeat;

  int  cyc = 0;
  int  total = 0;
  int  bad = 0;
  bit  end_req = 1'b0;
  ev_t sb_q[$];

  key_debounce_bank #(
    .N_KEYS         (NK),
    .DEBOUNCE_CYCLES(8),
    .REPEAT_DELAY   (20),
    .REPEAT_PERIOD  (5)
  ) dut (
    .clkin      (clk),
    .rst        (rst),
    .key_raw    (key_raw),
    .repeat_en  (repeat_en),
    .key_level  (key_level),
    .key_press  (key_press),
    .key_release(key_release),
    .key_repeat (key_repeat)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic wait_cyc(input int t);
    while (cyc < t) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push(input int c, input int kind, input int k);
    ev_t e;
    e.cyc  = c;
    e.kind = kind;
    e.key  = k;
    sb_q.push_back(e);
  endtask

  // Monitor: pop the events due this cycle and compare against the DUT
  logic [NK-1:0] exp_level = '0;
  always @(negedge clk) begin : monitor
    logic [NK-1:0] ep;
    logic [NK-1:0] er;
    logic [NK-1:0] et;
    ev_t           ev;
    ep = '0;
    er = '0;
    et = '0;
    if (cyc >= 1) begin
      while (sb_q.size() > 0 && sb_q[0].cyc <= cyc) begin
        ev = sb_q.pop_front();
        case (ev.kind)
          EV_PRESS: begin ep[ev.key] = 1'b1; exp_level[ev.key] = 1'b1; end
          EV_REL:   begin er[ev.key] = 1'b1; exp_level[ev.key] = 1'b0; end
          EV_REP:   et[ev.key] = 1'b1;
          default:  exp_level = '0;
        endcase
      end
      if ((key_press | key_release | key_repeat | ep | er | et) != '0) begin
        total++;
        if (key_press !== ep) begin
          bad++;
          $display("FAIL press cyc=%0d got=%b exp=%b", cyc, key_press, ep);
        end
        total++;
        if (key_release !== er) begin
          bad++;
          $display("FAIL release cyc=%0d got=%b exp=%b", cyc, key_release, er);
        end
        total++;
        if (key_repeat !== et) begin
          bad++;
          $display("FAIL repeat cyc=%0d got=%b exp=%b", cyc, key_repeat, et);
        end
      end
      total++;
      if (key_level !== exp_level) begin
        bad++;
        $display("FAIL level cyc=%0d got=%b exp=%b", cyc, key_level, exp_level);
      end
      if (end_req) begin
        end_req = 1'b0;
        total++;
        if (sb_q.size() != 0) begin
          bad++;
          $display("FAIL missing_events cyc=%0d got=%0d left exp=0 (next cyc=%0d key=%0d)",
                   cyc, sb_q.size(), sb_q[0].cyc, sb_q[0].key);
        end
      end
    end
  end

  // Directed stimulus; expected pulses are hand-computed (press/release land 9 cycles after the pad edge)
  initial begin
    rst       = 1'b1;
    key_raw   = '1;
    repeat_en = '0;
    wait_cyc(3);
    rst = 1'b0;

    // Clean press/release on enter, no repeat
    wait_cyc(20);
    key_raw[KEY_E] = 1'b0;
    push(29, EV_PRESS, KEY_E);
    push(79, EV_REL, KEY_E);
    wait_cyc(70);
    key_raw[KEY_E] = 1'b1;

    // Press bounce on up: never stable for 8 samples
    wait_cyc(100); key_raw[KEY_U] = 1'b0;
    wait_cyc(103); key_raw[KEY_U] = 1'b1;
    wait_cyc(105); key_raw[KEY_U] = 1'b0;
    wait_cyc(109); key_raw[KEY_U] = 1'b1;

    // Auto-repeat on down
    wait_cyc(150);
    repeat_en[KEY_D] = 1'b1;
    key_raw[KEY_D]   = 1'b0;
    push(159, EV_PRESS, KEY_D);
    for (int i = 0; i < 7; i++) push(179 + 5 * i, EV_REP, KEY_D);
    push(219, EV_REL, KEY_D);
    wait_cyc(210);
    key_raw[KEY_D] = 1'b1;
    wait_cyc(230);
    repeat_en[KEY_D] = 1'b0;

    // Release bounce on left
    wait_cyc(250);
    key_raw[KEY_L] = 1'b0;
    push(259, EV_PRESS, KEY_L);
    wait_cyc(280); key_raw[KEY_L] = 1'b1;
    wait_cyc(283); key_raw[KEY_L] = 1'b0;
    wait_cyc(285); key_raw[KEY_L] = 1'b1;
    push(294, EV_REL, KEY_L);

    // Simultaneous right and enter
    wait_cyc(320);
    key_raw[KEY_R] = 1'b0;
    key_raw[KEY_E] = 1'b0;
    push(329, EV_PRESS, KEY_E);
    push(329, EV_PRESS, KEY_R);
    wait_cyc(340);
    key_raw[KEY_R] = 1'b1;
    key_raw[KEY_E] = 1'b1;
    push(349, EV_REL, KEY_E);
    push(349, EV_REL, KEY_R);

    // Reset while up is held: no release, fresh press afterwards
    wait_cyc(380);
    key_raw[KEY_U] = 1'b0;
    push(389, EV_PRESS, KEY_U);
    wait_cyc(400);
    rst = 1'b1;
    push(400, EV_RST, 0);
    push(410, EV_PRESS, KEY_U);
    wait_cyc(401);
    rst = 1'b0;
    wait_cyc(440);
    key_raw[KEY_U] = 1'b1;
    push(449, EV_REL, KEY_U);

    wait_cyc(470);
    end_req = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/key_debounce_bank.md
Name: key_debounce_bank

Overview:
- Upstream front end for the countdown/display controller.
- Takes the five raw, active-low, bouncy push-button pads (enter, up, down, left, right). Synchronises and debounces each one independently.
- Outputs a clean level plus single-cycle press, release and auto-repeat pulses.
- The controller acts on these pulses. It no longer runs its own per-key debounce counters.

Parameters:
- N_KEYS, 5, number of independent key channels.
- DEBOUNCE_CYCLES, 1000000, consecutive stable samples needed to accept a transition (20 ms at 50 MHz); must be >= 2.
- REPEAT_DELAY, 25000000, held cycles after the press pulse before the first repeat pulse (500 ms).
- REPEAT_PERIOD, 10000000, cycles between subsequent repeat pulses (200 ms); must be >= 1.

Ports:
- clkin, in, 1, system clock (50 MHz).
- rst, in, 1, synchronous active-high reset.
- key_raw, in, N_KEYS, raw pad inputs, 0 = pressed.
- repeat_en, in, N_KEYS, per-key auto-repeat enable, sampled every cycle.
- key_level, out, N_KEYS, debounced state, 1 = pressed.
- key_press, out, N_KEYS, one-cycle pulse on accepted press.
- key_release, out, N_KEYS, one-cycle pulse on accepted release.
- key_repeat, out, N_KEYS, one-cycle pulse per auto-repeat tick while held.

Behaviour:
- Clock and reset:
  - One clock, clkin. Reset is synchronous and active-high on rst.
  - Reset drives all outputs to 0, every channel FSM to IDLE, and all counters to 0.
  - Reset also sets both synchroniser flops to 1 (released).
- Synchroniser:
  - Two-flop synchroniser per key on key_raw.
  - Internal pressed sample p = ~sync2.
- Per-channel FSM (counters are $clog2 of the largest parameter they compare against):
  - IDLE:
    - p=1 moves to PRESS_WAIT with deb_cnt=1.
    - Otherwise deb_cnt=0.
  - PRESS_WAIT:
    - p=1 and deb_cnt==DEBOUNCE_CYCLES-1: move to HELD; key_press=1 for one cycle; key_level=1 from the same cycle; rep_cnt=0.
    - p=1 and deb_cnt below that value: deb_cnt++.
    - p=0: return to IDLE with deb_cnt=0. No pulse.
  - HELD:
    - p=1:
      - rep_cnt++ (saturating).
      - If repeat_en=1, key_repeat pulses when rep_cnt reaches REPEAT_DELAY, then every REPEAT_PERIOD cycles after that.
      - If repeat_en=0, no repeat pulses; rep_cnt still runs.
    - p=0: move to RELEASE_WAIT with deb_cnt=1; rep_cnt frozen.
  - RELEASE_WAIT:
    - p=0 and deb_cnt==DEBOUNCE_CYCLES-1: move to IDLE; key_release=1 for one cycle; key_level=0 from the same cycle.
    - p=0 and deb_cnt below that value: deb_cnt++.
    - p=1: return to HELD with deb_cnt=0. No new press pulse; rep_cnt resumes.
- Latency:
  - A clean press that first appears on key_raw in cycle t gives p=1 from t+2.
  - key_press is asserted in cycle t+2+DEBOUNCE_CYCLES-1.
  - The same latency applies to release.
- Pulse rules:
  - key_press, key_release and key_repeat are never asserted together on one key.
  - key_repeat is never asserted on the key_press cycle.
- Independence:
  - Channels share nothing except clkin and rst.
  - Simultaneous presses on several keys give same-cycle pulses on each.
- Reset mid-operation:
  - Reset in any state produces no release pulse.
  - After reset deasserts, a key held down must debounce afresh and produces a new key_press.
- Consumer view:
  - The countdown controller uses key_release for enter, up, down, left and right. This preserves its act-on-release behaviour.
  - key_repeat is available for fast digit scrolling.

Decomposition:
- Shared package (key_pkg):
  - Channel state enum {IDLE, PRESS_WAIT, HELD, RELEASE_WAIT}.
  - Key index constants KEY_E=0, KEY_U=1, KEY_D=2, KEY_L=3, KEY_R=4.
  - Default timing constants for 50 MHz.
- Sub-module key_debounce_channel: synchroniser, FSM and counters for one key.
  - The bank instantiates it N_KEYS times in a generate loop.
  - Parameters are passed through.

Test Plan (simulation parameters DEBOUNCE_CYCLES=8, REPEAT_DELAY=20, REPEAT_PERIOD=5, N_KEYS=5):
1. Clean press: key_raw[0] goes 1->0 at cycle 10, held to cycle 60, repeat_en=0.
   - key_press[0] pulses at cycle 19; key_level[0]=1 from 19.
   - After release at cycle 60, key_release[0] pulses at 69; key_level[0]=0 from 69.
   - No key_repeat.
2. Press bounce: key_raw[1] low for 3 cycles, high for 2, low for 4, then high.
   - No key_press[1] and key_level[1] stays 0 throughout.
3. Auto-repeat: repeat_en[2]=1; key_raw[2] low from cycle 0 to 60.
   - key_press[2] pulses at cycle 9.
   - key_repeat[2] pulses at cycles 29, 34, 39, 44, 49, 54, 59.
   - No repeat pulses after release.
4. Release bounce: key 3 in HELD; release for 3 cycles, re-press for 2, then release cleanly.
   - Exactly one key_release[3], 9 cycles after the final release edge.
   - No second key_press[3].
5. Simultaneous keys: key_raw[4] and key_raw[0] both fall in the same cycle.
   - key_press[4] and key_press[0] pulse in the same cycle.
   - Other channels stay idle.
6. Reset mid-hold: rst=1 for 1 cycle while key 1 is HELD and still pressed.
   - All outputs are 0 the cycle after.
   - No key_release.
   - key_press[1] pulses again 9 cycles after rst deasserts.
